// File: rtl/nios_debug_host_pkg.sv
// Shared definitions for the Nios II debug host scan initiator.
//   state_t          : scan FSM states
//   IR_*             : virtual-JTAG IR codes understood by the debug slave
//   DEFAULT_DR_WIDTH : DR scan length of the debug slave
//   scan_latency()   : accept-to-response cycle count for a given geometry
package nios_debug_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RSP  = 3'd6
    } state_t;

    localparam logic [1:0] IR_OCIMEM  = 2'd0;
    localparam logic [1:0] IR_TRACE   = 2'd1;
    localparam logic [1:0] IR_BREAK   = 2'd2;
    localparam logic [1:0] IR_CONTROL = 2'd3;

    localparam int DEFAULT_DR_WIDTH = 38;

    function automatic int scan_latency(input int dr_width, input int tck_div);
        return 1 + (dr_width + 4) * 2 * tck_div;
    endfunction

endpackage

// File: rtl/nios_debug_host_scan_if.sv
// Command/response handshake bundle of the debug host scan initiator.
//   cmd_valid/cmd_ready/cmd_ir/cmd_dr : scan request
//   rsp_valid/rsp_ready/rsp_dr/rsp_ir : scan result
// master = requester side, slave = nios_debug_host_scan.
interface nios_debug_host_scan_if #(
    parameter int DR_WIDTH = nios_debug_host_pkg::DEFAULT_DR_WIDTH
);
    import nios_debug_host_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [1:0]          rsp_ir;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir
    );

endinterface

// File: rtl/nios_debug_host_tck_gen.sv
// Divided TCK generator for the debug host scan initiator.
//   clk, reset : system clock, synchronous active-high reset
//   enable     : run TCK; when low TCK is parked low and the phase restarts
//   tck        : generated TCK (each period: TCK_DIV low, then TCK_DIV high)
//   rise_pulse : one clk, the cycle before TCK goes high
//   fall_pulse : one clk, the cycle before TCK goes low (period boundary)
module nios_debug_host_tck_gen
    import nios_debug_host_pkg::*;
#(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tck,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(TCK_DIV - 1);

    logic [CW-1:0] half_cnt;
    logic          half_done;

    assign half_done = (half_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            half_cnt <= HALF_LAST;
            tck      <= 1'b0;
        end else if (half_done) begin
            half_cnt <= HALF_LAST;
            tck      <= ~tck;
        end else begin
            half_cnt <= half_cnt - 1'b1;
        end
    end

    // Pulses mark the clk edge on which TCK toggles, so the FSM acts in step.
    assign rise_pulse = enable & half_done & ~tck;
    assign fall_pulse = enable & half_done & tck;

endmodule

// File: rtl/nios_debug_host_scan.sv
// Host-side virtual-JTAG scan initiator for the Nios II on-chip debug slave.
// Takes an IR code plus DR word, walks UIR/CDR/SDR/UDR/RTI with a divided
// TCK, and returns the DR word captured from TDO.
//   clk, reset      : system clock, synchronous active-high reset
//   bus (slave)     : cmd_* request and rsp_* result handshakes
//   vjh_tck/tdi/tdo : serial scan pins toward the debug slave
//   vjh_ir_in/out   : IR presented to / status from the debug slave
//   vjh_uir..rti    : one-hot virtual JTAG state strobes
// Optional build macro NIOS_DEBUG_HOST_IR_READBACK_EN: capture vjh_ir_out at
// the end of UIR and return it on rsp_ir (otherwise rsp_ir is 2'b00).
//
// state | meaning
// IDLE  | ready for a command
// UIR   | IR update, one TCK period
// CDR   | DR capture, one TCK period
// SDR   | DR shift, DR_WIDTH TCK periods
// UDR   | DR update, one TCK period
// RTI   | run-test/idle, one TCK period
// RSP   | result held until accepted
module nios_debug_host_scan
    import nios_debug_host_pkg::*;
#(
    parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
    parameter int TCK_DIV  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    nios_debug_host_scan_if.slave  bus,
    output logic                   vjh_tck,
    output logic                   vjh_tdi,
    input  logic                   vjh_tdo,
    output logic [1:0]             vjh_ir_in,
    input  logic [1:0]             vjh_ir_out,
    output logic                   vjh_uir,
    output logic                   vjh_cdr,
    output logic                   vjh_sdr,
    output logic                   vjh_udr,
    output logic                   vjh_rti
);

    localparam int BW = $clog2(DR_WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

    state_t              state;
    state_t              state_nxt;
    logic                armed;
    logic                tck_en;
    logic                rise_pulse;
    logic                fall_pulse;
    logic                cmd_fire;
    logic [DR_WIDTH-1:0] shift_q;
    logic [DR_WIDTH-1:0] cap_q;
    logic [BW-1:0]       bit_cnt;
    logic [1:0]          ir_q;

    nios_debug_host_tck_gen #(
        .TCK_DIV    (TCK_DIV)
    ) u_tck_gen (
        .clk        (clk),
        .reset      (reset),
        .enable     (tck_en),
        .tck        (vjh_tck),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    assign cmd_fire = bus.cmd_valid & bus.cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (cmd_fire)                     state_nxt = ST_UIR;
            ST_UIR:  if (fall_pulse)                   state_nxt = ST_CDR;
            ST_CDR:  if (fall_pulse)                   state_nxt = ST_SDR;
            ST_SDR:  if (fall_pulse && bit_cnt == '0)  state_nxt = ST_UDR;
            ST_UDR:  if (fall_pulse)                   state_nxt = ST_RTI;
            ST_RTI:  if (fall_pulse)                   state_nxt = ST_RSP;
            ST_RSP:  if (bus.rsp_ready)                state_nxt = ST_IDLE;
            default:                                   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state == ST_IDLE) && armed;
        bus.rsp_valid = (state == ST_RSP);
        vjh_uir       = (state == ST_UIR);
        vjh_cdr       = (state == ST_CDR);
        vjh_sdr       = (state == ST_SDR);
        vjh_udr       = (state == ST_UDR);
        vjh_rti       = (state == ST_RTI);
        vjh_tdi       = (state == ST_SDR) && shift_q[0];
        tck_en        = (state != ST_IDLE) && (state != ST_RSP);
    end

    // armed keeps cmd_ready low for the first cycle after reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed   <= 1'b0;
            shift_q <= '0;
            cap_q   <= '0;
            bit_cnt <= '0;
            ir_q    <= 2'b00;
        end else begin
            armed <= 1'b1;
            if (cmd_fire) begin
                ir_q    <= bus.cmd_ir;
                shift_q <= bus.cmd_dr;
            end
            if (state == ST_CDR) begin
                bit_cnt <= BIT_LAST;
            end else if (state == ST_SDR && fall_pulse) begin
                shift_q <= shift_q >> 1;
                bit_cnt <= bit_cnt - 1'b1;
            end
            // Capture fills from the MSB so the first TDO bit ends in bit 0.
            if (state == ST_SDR && rise_pulse) begin
                cap_q <= {vjh_tdo, cap_q[DR_WIDTH-1:1]};
            end
        end
    end

    assign vjh_ir_in  = ir_q;
    assign bus.rsp_dr = cap_q;

`ifdef NIOS_DEBUG_HOST_IR_READBACK_EN
    logic [1:0] ir_rb_q;

    always_ff @(posedge clk) begin
        if (reset)                              ir_rb_q <= 2'b00;
        else if (state == ST_UIR && fall_pulse) ir_rb_q <= vjh_ir_out;
    end

    assign bus.rsp_ir = ir_rb_q;
`else
    logic [1:0] unused_ir_out;
    assign unused_ir_out = vjh_ir_out;
    assign bus.rsp_ir    = 2'b00;
`endif

endmodule

// File: tb/tb_nios_debug_host_scan.sv
module tb_nios_debug_host_scan;
    import nios_debug_host_pkg::*;

    localparam int W = 38;
    localparam int D = 2;
    localparam int LAT = 1 + (W + 4) * 2 * D;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // ---------------- default-geometry DUT ----------------
    nios_debug_host_scan_if #(.DR_WIDTH(W)) bus ();
    logic       vjh_tck, vjh_tdi, vjh_tdo;
    logic [1:0] vjh_ir_in, vjh_ir_out;
    logic       vjh_uir, vjh_cdr, vjh_sdr, vjh_udr, vjh_rti;
    int         tdo_mode;     // 0 random target, 1 loopback, 2 tied high
    logic       tdo_rand;

    assign vjh_tdo = (tdo_mode == 1) ? vjh_tdi : (tdo_mode == 2) ? 1'b1 : tdo_rand;

    nios_debug_host_scan #(.DR_WIDTH(W), .TCK_DIV(D)) u_dut (
        .clk(clk), .reset(reset), .bus(bus),
        .vjh_tck(vjh_tck), .vjh_tdi(vjh_tdi), .vjh_tdo(vjh_tdo),
        .vjh_ir_in(vjh_ir_in), .vjh_ir_out(vjh_ir_out),
        .vjh_uir(vjh_uir), .vjh_cdr(vjh_cdr), .vjh_sdr(vjh_sdr),
        .vjh_udr(vjh_udr), .vjh_rti(vjh_rti)
    );

    // ---------------- small-geometry DUT ----------------
    nios_debug_host_scan_if #(.DR_WIDTH(2)) bus_s ();
    logic       s_tck, s_tdi, s_tdo;
    logic [1:0] s_ir_in;
    logic [1:0] s_ir_out = 2'b01;
    logic       s_uir, s_cdr, s_sdr, s_udr, s_rti;

    assign s_tdo = s_tdi;

    nios_debug_host_scan #(.DR_WIDTH(2), .TCK_DIV(1)) u_dut_small (
        .clk(clk), .reset(reset), .bus(bus_s),
        .vjh_tck(s_tck), .vjh_tdi(s_tdi), .vjh_tdo(s_tdo),
        .vjh_ir_in(s_ir_in), .vjh_ir_out(s_ir_out),
        .vjh_uir(s_uir), .vjh_cdr(s_cdr), .vjh_sdr(s_sdr),
        .vjh_udr(s_udr), .vjh_rti(s_rti)
    );

    // ---------------- target model / protocol monitor ----------------
    logic tdo_q[$];
    logic tdi_q[$];
    int   onehot_err, idle_err, irin_err;
    logic [1:0] exp_ir;
    logic tck_q = 1'b0;

    always @(negedge clk) begin
        if (vjh_tck && !tck_q && vjh_sdr) begin
            tdo_q.push_back(vjh_tdo);
            tdi_q.push_back(vjh_tdi);
        end
        if (!vjh_tck && tck_q) tdo_rand = 1'($urandom_range(0, 1));
        if ($countones({vjh_uir, vjh_cdr, vjh_sdr, vjh_udr, vjh_rti}) > 1) onehot_err++;
        if ((bus.cmd_ready || bus.rsp_valid) &&
            ({vjh_uir, vjh_cdr, vjh_sdr, vjh_udr, vjh_rti} != 5'b0 || vjh_tck)) idle_err++;
        if ({vjh_uir, vjh_cdr, vjh_sdr, vjh_udr, vjh_rti} != 5'b0 && vjh_ir_in !== exp_ir) irin_err++;
        tck_q = vjh_tck;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] exp_rsp_ir(input logic [1:0] ir_out);
`ifdef NIOS_DEBUG_HOST_IR_READBACK_EN
        return ir_out;
`else
        return 2'b00 & ir_out;
`endif
    endfunction

    task automatic run_scan(input string tag, input logic [1:0] ir, input logic [W-1:0] dr,
                            input logic [1:0] ir_out, input int hold,
                            input bit use_model, input logic [W-1:0] exp_fixed);
        int n;
        int lat;
        int tdi_bad;
        logic [W-1:0] exp_dr;
        logic [W-1:0] held_dr;
        bit held_ok;
        n = 0;
        while (!bus.cmd_ready && n < 400) begin @(posedge clk); #1; n++; end
        check({tag, "_ready"}, 64'(bus.cmd_ready), 64'd1);
        tdo_q.delete(); tdi_q.delete();
        onehot_err = 0; idle_err = 0; irin_err = 0;
        exp_ir = ir;
        vjh_ir_out = ir_out;
        bus.cmd_valid = 1'b1; bus.cmd_ir = ir; bus.cmd_dr = dr; bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.cmd_ir = ~ir; bus.cmd_dr = ~dr;
        lat = 1;
        while (!bus.rsp_valid && lat < 400) begin @(posedge clk); #1; lat++; end
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_sdr_rises"}, 64'(tdi_q.size()), 64'(W));
        tdi_bad = 0;
        foreach (tdi_q[i]) if (i < W && tdi_q[i] !== dr[i]) tdi_bad++;
        check({tag, "_tdi_bits"}, 64'(tdi_bad), 64'd0);
        exp_dr = exp_fixed;
        if (use_model) begin
            exp_dr = '0;
            foreach (tdo_q[i]) if (i < W) exp_dr[i] = tdo_q[i];
        end
        check({tag, "_rsp_dr"}, 64'(bus.rsp_dr), 64'(exp_dr));
        check({tag, "_rsp_ir"}, 64'(bus.rsp_ir), 64'(exp_rsp_ir(ir_out)));
        check({tag, "_protocol"}, 64'(onehot_err + idle_err + irin_err), 64'd0);
        held_dr = bus.rsp_dr;
        held_ok = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!bus.rsp_valid || bus.rsp_dr !== held_dr || bus.cmd_ready) held_ok = 1'b0;
        end
        if (hold > 0) check({tag, "_hold"}, 64'(held_ok), 64'd1);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, "_after_rsp"}, 64'({bus.cmd_ready, bus.rsp_valid}), 64'b10);
    endtask

    initial begin
        logic [63:0]  r64;
        logic [W-1:0] dr;
        logic [1:0]   ir;
        int n, lat;
        int cu, cc, cs, cd, cr, oh;
        bit saw;

        reset = 1'b1;
        tdo_mode = 0; tdo_rand = 1'b0; exp_ir = 2'b00; vjh_ir_out = 2'b00;
        bus.cmd_valid = 1'b0; bus.cmd_ir = 2'b00; bus.cmd_dr = '0; bus.rsp_ready = 1'b0;
        bus_s.cmd_valid = 1'b0; bus_s.cmd_ir = 2'b00; bus_s.cmd_dr = '0; bus_s.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 64'({bus.cmd_ready, bus.rsp_valid, vjh_tck, vjh_tdi, vjh_uir, vjh_cdr,
                                 vjh_sdr, vjh_udr, vjh_rti, vjh_ir_in, bus.rsp_ir}), 64'd0);
        check("reset_rsp_dr", 64'(bus.rsp_dr), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(bus.cmd_ready), 64'd1);

        // Loopback with the reference pattern
        tdo_mode = 1;
        run_scan("loopback", IR_BREAK, 38'h2A_5555_AAAA, 2'b11, 0, 1'b0, 38'h2A_5555_AAAA);

        // TDO tied high, zero data shifted in
        tdo_mode = 2;
        run_scan("tdo_ones", IR_OCIMEM, '0, 2'b10, 0, 1'b0, {W{1'b1}});

        // Random target data, response back-pressured for 20 cycles
        tdo_mode = 0;
        r64 = {$urandom(), $urandom()};
        run_scan("hold", IR_TRACE, r64[W-1:0], 2'b01, 20, 1'b1, '0);

        for (int k = 0; k < 4; k++) begin
            r64 = {$urandom(), $urandom()};
            ir = 2'($urandom_range(0, 3));
            run_scan($sformatf("rand%0d", k), ir, r64[W-1:0], 2'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'b1, '0);
        end

        // Reset in the middle of the DR shift
        r64 = {$urandom(), $urandom()};
        dr = r64[W-1:0];
        tdo_q.delete(); tdi_q.delete();
        exp_ir = IR_CONTROL;
        bus.cmd_valid = 1'b1; bus.cmd_ir = IR_CONTROL; bus.cmd_dr = dr;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        while (tdi_q.size() < 10 && n < 400) begin @(posedge clk); #1; n++; end
        check("rst_mid_reach", 64'(tdi_q.size()), 64'd10);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_outs", 64'({bus.cmd_ready, bus.rsp_valid, vjh_tck, vjh_tdi, vjh_uir, vjh_cdr,
                                   vjh_sdr, vjh_udr, vjh_rti, vjh_ir_in, bus.rsp_ir}), 64'd0);
        check("rst_mid_dr", 64'(bus.rsp_dr), 64'd0);
        saw = 1'b0;
        repeat (200) begin @(posedge clk); #1; if (bus.rsp_valid) saw = 1'b1; end
        check("rst_mid_no_rsp", 64'(saw), 64'd0);
        r64 = {$urandom(), $urandom()};
        run_scan("after_rst", IR_BREAK, r64[W-1:0], 2'b11, 0, 1'b1, '0);

        // Minimum geometry: TCK_DIV=1, DR_WIDTH=2, loopback
        bus_s.cmd_valid = 1'b1; bus_s.cmd_ir = IR_CONTROL; bus_s.cmd_dr = 2'b10;
        @(posedge clk); #1;
        bus_s.cmd_valid = 1'b0; bus_s.cmd_dr = 2'b01;
        lat = 0; cu = 0; cc = 0; cs = 0; cd = 0; cr = 0; oh = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus_s.rsp_valid && lat == 0) lat = c;
            cu += int'(s_uir); cc += int'(s_cdr); cs += int'(s_sdr);
            cd += int'(s_udr); cr += int'(s_rti);
            if ($countones({s_uir, s_cdr, s_sdr, s_udr, s_rti}) > 1) oh++;
            if (lat == 0) begin @(posedge clk); #1; end
        end
        check("small_latency", 64'(lat), 64'd13);
        check("small_durations", 64'({8'(cu), 8'(cc), 8'(cs), 8'(cd), 8'(cr)}),
              64'({8'd2, 8'd2, 8'd4, 8'd2, 8'd2}));
        check("small_onehot", 64'(oh), 64'd0);
        check("small_rsp_dr", 64'(bus_s.rsp_dr), 64'b10);
        check("small_rsp_ir", 64'(bus_s.rsp_ir), 64'(exp_rsp_ir(2'b01)));
        check("small_ir_in", 64'(s_ir_in), 64'(IR_CONTROL));
        bus_s.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus_s.rsp_ready = 1'b0;
        check("small_after_rsp", 64'({bus_s.cmd_ready, bus_s.rsp_valid}), 64'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
